hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage RV32 core; sits beside decode and sequences the F/D/E stage registers.
- Keeps a shadow pipeline of the in-flight destination registers in E, M and W.
- Detects data hazards against the rs1/rs2 in decode and issues stall and flush controls.
- Handles control redirects from E, and runs a start/done handshake with the multi-cycle mul/div unit while holding the pipeline.

Parameters:
- CNT_W, 32: width of the saturating stall-cycle performance counter.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-low reset
- d_valid  in  1  decode holds a valid instruction
- d_rs1, d_rs2  in  5 each  source register addresses in decode
- d_use_rs1, d_use_rs2  in  1 each  instruction actually reads rs1 / rs2
- d_rd  in  5  destination register in decode
- d_reg_write  in  1  decode instruction writes rd
- d_is_load  in  1  decode instruction is a load
- d_is_md  in  1  decode instruction is mul/div
- ex_redirect  in  1  taken branch or jump resolved in E
- md_done  in  1  mul/div result ready, 1-cycle pulse
- stall_f  out  1  hold PC
- stall_d  out  1  hold the F/D register
- stall_e  out  1  hold the D/E register
- flush_d  out  1  bubble into the F/D register
- flush_e  out  1  bubble into the D/E register
- md_start  out  1  1-cycle start pulse to the mul/div unit
- stall_cnt  out  CNT_W  count of cycles with stall_d=1

Behaviour:
- Shadow slots E, M, W: each holds {valid, rd, reg_write, is_load, is_md}.
- Shadow slot update on each clk edge:
  - stall_e=1: E holds, M <= bubble, W <= M.
  - stall_e=0: M <= E, W <= M; E <= bubble if flush_e or !d_valid, else E <= decode fields.
- Match definition: slot valid && reg_write && rd!=0 && ((d_use_rs1 && rd==d_rs1) || (d_use_rs2 && rd==d_rs2)). Register x0 never matches.
- Load-use hazard: match in E with is_load -> stall_f=1, stall_d=1, flush_e=1.
- A match in W never stalls; decode's writeback forwarding covers it.
- mul/div FSM, states IDLE and MD_WAIT:
  - IDLE: if E is valid with is_md -> md_start=1 and stall_f=stall_d=stall_e=1 in that cycle; next state MD_WAIT.
  - MD_WAIT: stall_f=stall_d=stall_e=1. On md_done, all three drop in the same cycle and the state returns to IDLE; E then advances.
  - md_done while in IDLE is ignored.
  - ex_redirect is ignored in MD_WAIT (E holds a mul/div op, not a branch).
- Redirect (IDLE only): flush_d=1, flush_e=1; stall_f=0, stall_d=0 even when a load-use hazard is present.
- Priority: MD stall > redirect > data hazard.
- All stall and flush outputs are combinational from the current state, the slots and the decode inputs. No added latency.
- stall_cnt increments on every cycle with stall_d=1 and saturates at all-ones.
- Reset asserted (low):
  - All slots invalid, state IDLE, stall_cnt=0.
  - All outputs 0 immediately, including in the middle of MD_WAIT.
  - The mul/div unit shares this reset.

Optional Feature:
- HAZARD_FULL_FWD_EN defined: the E and M stages have full forwarding, so only the load-use rule and the MD rules stall.
- HAZARD_FULL_FWD_EN undefined: no EX/MEM forwarding. Any match in E or M stalls, with stall_f=stall_d=1 and flush_e=1.

Decomposition:
- hazard_pkg holds:
  - the slot struct typedef,
  - the md_state_t enum (IDLE, MD_WAIT),
  - the REG_ZERO=5'd0 constant,
  - the REG_ADDR_W=5 constant.
- One sub-module, md_sequencer: holds the FSM and generates md_start and the MD stall.

Test Plan:
- Load-use: lw x5 then add x6,x5,x1 -> stall_f=stall_d=flush_e=1 for exactly 1 cycle; add proceeds next cycle; stall_cnt=1.
- x0 and W-stage cases:
  - lw x0 followed by add x6,x0,x1 -> no stall.
  - A producer in W only -> no stall.
- mul/div: mul x7 reaches E, md_done pulses 4 cycles after md_start -> md_start high 1 cycle; stall_e=stall_d=1 for 4 cycles; release in the md_done cycle; stall_cnt=4.
- Redirect during load-use: ex_redirect=1 in the same cycle as a load-use match -> flush_d=flush_e=1, stall_f=stall_d=0.
- Non-forwarding build: with the macro undefined, add x5 then add x6,x5 -> 2 stall cycles. With HAZARD_FULL_FWD_EN defined, the same sequence gives 0 stall cycles.
- Reset during MD_WAIT: reset driven low in cycle 2 of MD_WAIT -> all outputs 0 at once; after release the FSM is IDLE, all slots are empty and stall_cnt=0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller:
// shadow-slot layout, mul/div sequencer states and register-match helper.
package hazard_pkg;

    localparam int                    REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO   = 5'd0;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  is_load;
        logic                  is_md;
    } slot_t;

    localparam slot_t SLOT_BUBBLE = '0;

    typedef enum logic {
        IDLE,
        MD_WAIT
    } md_state_t;

    // x0 is hardwired to zero, so a producer targeting it never creates a dependency.
    function automatic logic slot_match(
        input slot_t                  s,
        input logic                   use_rs1,
        input logic [REG_ADDR_W-1:0]  rs1,
        input logic                   use_rs2,
        input logic [REG_ADDR_W-1:0]  rs2
    );
        return s.valid && s.reg_write && (s.rd != REG_ZERO) &&
               ((use_rs1 && (s.rd == rs1)) || (use_rs2 && (s.rd == rs2)));
    endfunction

endpackage

// File: rtl/hazard_ctrl_md_sequencer.sv
// Mul/div handshake FSM: pulses md_start when a mul/div op sits in E and
// holds the pipeline until the unit answers with md_done.
module md_sequencer
    import hazard_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic e_is_md,
    input  logic md_done,
    output logic md_start,
    output logic md_stall
);

    md_state_t state_q, state_d;

    // NOTE: every output of a combinational block gets a default first, so no path leaves a latch behind.
    always_comb begin
        state_d  = state_q;
        md_start = 1'b0;
        md_stall = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (e_is_md) begin
                    md_start = 1'b1;
                    md_stall = 1'b1;
                    state_d  = MD_WAIT;
                end
            end
            MD_WAIT: begin
                // Release in the md_done cycle itself so E advances on the next edge.
                if (md_done) begin
                    state_d = IDLE;
                end else begin
                    md_stall = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32 core: shadow E/M/W slots, stall/flush
// generation and a saturating stall counter. Optional macro: HAZARD_FULL_FWD_EN.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  d_valid,
    input  logic [REG_ADDR_W-1:0] d_rs1,
    input  logic [REG_ADDR_W-1:0] d_rs2,
    input  logic                  d_use_rs1,
    input  logic                  d_use_rs2,
    input  logic [REG_ADDR_W-1:0] d_rd,
    input  logic                  d_reg_write,
    input  logic                  d_is_load,
    input  logic                  d_is_md,
    input  logic                  ex_redirect,
    input  logic                  md_done,
    output logic                  stall_f,
    output logic                  stall_d,
    output logic                  stall_e,
    output logic                  flush_d,
    output logic                  flush_e,
    output logic                  md_start,
    output logic [CNT_W-1:0]      stall_cnt
);

    slot_t            e_q, e_d, m_q, m_d, w_q, w_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             md_start_raw, md_stall;
    logic             match_e, load_use, data_hazard;
    logic             unused_w;

    md_sequencer u_md_seq (
        .clk      (clk),
        .reset    (reset),
        .e_is_md  (e_q.valid && e_q.is_md),
        .md_done  (md_done),
        .md_start (md_start_raw),
        .md_stall (md_stall)
    );

    always_comb begin
        match_e  = slot_match(e_q, d_use_rs1, d_rs1, d_use_rs2, d_rs2);
        load_use = match_e && e_q.is_load;
`ifdef HAZARD_FULL_FWD_EN
        data_hazard = load_use;
`else
        data_hazard = load_use || match_e ||
                      slot_match(m_q, d_use_rs1, d_rs1, d_use_rs2, d_rs2);
`endif
    end

    // Priority: mul/div hold > redirect > data hazard; everything is forced low under reset.
    always_comb begin
        stall_f  = 1'b0;
        stall_d  = 1'b0;
        stall_e  = 1'b0;
        flush_d  = 1'b0;
        flush_e  = 1'b0;
        md_start = 1'b0;
        if (reset) begin
            md_start = md_start_raw;
            if (md_stall) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
            end else if (ex_redirect) begin
                flush_d = 1'b1;
                flush_e = 1'b1;
            end else if (data_hazard) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end
        end
    end

    always_comb begin
        w_d = m_q;
        if (stall_e) begin
            e_d = e_q;
            m_d = SLOT_BUBBLE;
        end else begin
            m_d = e_q;
            if (flush_e || !d_valid) begin
                e_d = SLOT_BUBBLE;
            end else begin
                e_d = '{valid: 1'b1, rd: d_rd, reg_write: d_reg_write,
                        is_load: d_is_load, is_md: d_is_md};
            end
        end
        stall_cnt_d = stall_cnt_q;
        if (stall_d && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_q         <= SLOT_BUBBLE;
            m_q         <= SLOT_BUBBLE;
            w_q         <= SLOT_BUBBLE;
            stall_cnt_q <= '0;
        end else begin
            e_q         <= e_d;
            m_q         <= m_d;
            w_q         <= w_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // W is tracked for visibility only: writeback forwarding means it never stalls decode.
    assign unused_w  = ^w_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by random
// traffic, all compared against an instruction-level pipeline model.
module tb_hazard_ctrl;

    localparam int CNT_W = 4;
`ifdef HAZARD_FULL_FWD_EN
    localparam bit FULL_FWD = 1'b1;
`else
    localparam bit FULL_FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic d_valid, d_use_rs1, d_use_rs2, d_reg_write, d_is_load, d_is_md;
    logic [4:0] d_rs1, d_rs2, d_rd;
    logic ex_redirect, md_done;
    logic stall_f, stall_d, stall_e, flush_d, flush_e, md_start;
    logic [CNT_W-1:0] stall_cnt;

    always #5 clk = ~clk;

    hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .d_valid(d_valid), .d_rs1(d_rs1), .d_rs2(d_rs2),
        .d_use_rs1(d_use_rs1), .d_use_rs2(d_use_rs2), .d_rd(d_rd),
        .d_reg_write(d_reg_write), .d_is_load(d_is_load), .d_is_md(d_is_md),
        .ex_redirect(ex_redirect), .md_done(md_done), .stall_f(stall_f),
        .stall_d(stall_d), .stall_e(stall_e), .flush_d(flush_d), .flush_e(flush_e),
        .md_start(md_start), .stall_cnt(stall_cnt)
    );

    // In-flight instructions by distance from decode: [0]=one ahead (E), [1]=M, [2]=W.
    typedef struct { bit v; bit [4:0] rd; bit wr; bit ld; bit md; } inst_t;
    inst_t       pipe [3];
    bit          m_busy;
    int unsigned m_cnt;
    bit          x_sf, x_sd, x_se, x_fd, x_fe, x_start;
    int          n_cmp = 0;
    int          n_err = 0;

    function automatic bit depends_on(inst_t p);
        return p.v && p.wr && (p.rd != 5'd0) &&
               ((d_use_rs1 && p.rd == d_rs1) || (d_use_rs2 && p.rd == d_rs2));
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) pipe[k] = '{0, 0, 0, 0, 0};
        m_busy = 0;
        m_cnt  = 0;
    endtask

    task automatic model_eval();
        bit hz, hold;
        hz = 0;
        // A load result is only usable two instructions later; without bypass any producer within two blocks.
        for (int k = 0; k < 2; k++)
            if (depends_on(pipe[k]) && (!FULL_FWD || (k == 0 && pipe[k].ld))) hz = 1;
        hold    = m_busy ? !md_done : (pipe[0].v && pipe[0].md);
        x_start = !m_busy && pipe[0].v && pipe[0].md;
        {x_sf, x_sd, x_se, x_fd, x_fe} = '0;
        if (hold)             {x_sf, x_sd, x_se} = 3'b111;
        else if (ex_redirect) {x_fd, x_fe} = 2'b11;
        else if (hz)          {x_sf, x_sd, x_fe} = 3'b111;
    endtask

    task automatic model_step();
        inst_t nxt;
        nxt = '{0, 0, 0, 0, 0};
        if (d_valid && !x_fe) nxt = '{1, d_rd, d_reg_write, d_is_load, d_is_md};
        pipe[2] = pipe[1];
        if (x_se) begin
            pipe[1] = '{0, 0, 0, 0, 0};
        end else begin
            pipe[1] = pipe[0];
            pipe[0] = nxt;
        end
        m_busy = m_busy ? !md_done : x_start;
        if (x_sd && m_cnt < (2 ** CNT_W) - 1) m_cnt++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sample();
        #1;
        model_eval();
        chk("stall_f",   32'(stall_f),   32'(x_sf));
        chk("stall_d",   32'(stall_d),   32'(x_sd));
        chk("stall_e",   32'(stall_e),   32'(x_se));
        chk("flush_d",   32'(flush_d),   32'(x_fd));
        chk("flush_e",   32'(flush_e),   32'(x_fe));
        chk("md_start",  32'(md_start),  32'(x_start));
        chk("stall_cnt", 32'(stall_cnt), m_cnt);
    endtask

    task automatic advance();
        model_step();
        @(negedge clk);
    endtask

    task automatic cyc();
        sample();
        advance();
    endtask

    task automatic set_inst(bit v, bit [4:0] rd, bit wr, bit ld, bit md,
                            bit u1, bit [4:0] r1, bit u2, bit [4:0] r2);
        d_valid = v; d_rd = rd; d_reg_write = wr; d_is_load = ld; d_is_md = md;
        d_use_rs1 = u1; d_rs1 = r1; d_use_rs2 = u2; d_rs2 = r2;
    endtask

    task automatic nop();                           set_inst(0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic lw(bit [4:0] rd, bit [4:0] a);   set_inst(1, rd, 1, 1, 0, 1, a, 0, 0); endtask
    task automatic add(bit [4:0] rd, bit [4:0] a, bit [4:0] b); set_inst(1, rd, 1, 0, 0, 1, a, 1, b); endtask
    task automatic mul(bit [4:0] rd, bit [4:0] a, bit [4:0] b); set_inst(1, rd, 1, 0, 1, 1, a, 1, b); endtask

    // Hold the current decode instruction until it leaves decode, with a bounded wait.
    task automatic issue();
        int guard = 0;
        do begin
            cyc();
            guard++;
        end while (x_sd && guard < 64);
        if (x_sd) begin
            n_cmp++;
            n_err++;
            $display("FAIL issue_timeout: observed still stalled after %0d cycles required release", guard);
        end
    endtask

    task automatic do_reset();
        reset = 0; ex_redirect = 0; md_done = 0;
        nop();
        model_reset();
        sample();
        @(negedge clk);
        reset = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed simulation still running required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 0; ex_redirect = 0; md_done = 0;
        nop();
        model_reset();
        @(negedge clk);
        do_reset();
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);

        // Load-use: lw x5 then add x6,x5,x1.
        lw(5, 1); issue();
        add(6, 5, 1);
        sample();
        chk("lu_stall_f", 32'(stall_f), 32'd1);
        chk("lu_flush_e", 32'(flush_e), 32'd1);
        advance();
        issue();
        nop(); cyc();
        chk("lu_cnt", 32'(stall_cnt), FULL_FWD ? 32'd1 : 32'd2);

        // Producers on x0 never create a hazard.
        do_reset();
        lw(0, 1); issue();
        add(6, 0, 1); issue();
        nop(); cyc();
        chk("x0_cnt", 32'(stall_cnt), 32'd0);

        // Producer already in W: no stall.
        do_reset();
        add(5, 1, 2); issue();
        nop(); cyc(); cyc();
        add(6, 5, 1); sample();
        chk("w_stall_d", 32'(stall_d), 32'd0);
        advance();

        // mul/div: md_done four cycles after md_start.
        do_reset();
        mul(7, 1, 2); issue();
        nop(); sample();
        chk("md_start_pulse", 32'(md_start), 32'd1);
        chk("md_stall_e0", 32'(stall_e), 32'd1);
        advance();
        sample();
        chk("md_start_once", 32'(md_start), 32'd0);
        advance();
        cyc(); cyc();
        md_done = 1; sample();
        chk("md_release_e", 32'(stall_e), 32'd0);
        chk("md_release_d", 32'(stall_d), 32'd0);
        advance();
        md_done = 0; cyc();
        chk("md_cnt", 32'(stall_cnt), 32'd4);

        // Redirect in the same cycle as a load-use match.
        do_reset();
        lw(5, 1); issue();
        add(6, 5, 1); ex_redirect = 1; sample();
        chk("rd_flush_d", 32'(flush_d), 32'd1);
        chk("rd_flush_e", 32'(flush_e), 32'd1);
        chk("rd_stall_f", 32'(stall_f), 32'd0);
        chk("rd_stall_d", 32'(stall_d), 32'd0);
        advance();
        ex_redirect = 0; nop(); cyc();

        // ALU-to-ALU dependency: only stalls without EX/MEM forwarding.
        do_reset();
        add(5, 1, 2); issue();
        add(6, 5, 1); issue();
        nop(); cyc();
        chk("alu_cnt", 32'(stall_cnt), FULL_FWD ? 32'd0 : 32'd2);

        // Reset asserted in the second MD_WAIT cycle.
        do_reset();
        mul(7, 1, 2); issue();
        nop(); cyc(); cyc();
        add(6, 7, 1); ex_redirect = 1;
        sample();
        #1 reset = 0;
        #1;
        chk("mrst_stall_f",  32'(stall_f),  32'd0);
        chk("mrst_stall_d",  32'(stall_d),  32'd0);
        chk("mrst_stall_e",  32'(stall_e),  32'd0);
        chk("mrst_flush_d",  32'(flush_d),  32'd0);
        chk("mrst_flush_e",  32'(flush_e),  32'd0);
        chk("mrst_md_start", 32'(md_start), 32'd0);
        chk("mrst_cnt",      32'(stall_cnt), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1; ex_redirect = 0;
        add(6, 7, 1); cyc();
        nop(); cyc();

        // Random traffic over a small register set to provoke dense hazards.
        for (int i = 0; i < 600; i++) begin
            if (!x_sd) begin
                case ($urandom_range(0, 5))
                    0: nop();
                    1: lw(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
                    2, 3: add(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
                    4: mul(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
                    default: add(0, 5'($urandom_range(0, 3)), 0);
                endcase
            end
            ex_redirect = ($urandom_range(0, 7) == 0);
            md_done     = m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
